// File: rtl/branch_predictor_pkg.sv
// Shared types and helpers for the bimodal/gshare branch predictor.
// Counter encoding, BTB entry layout and the PHT reset value live here.
package branch_predictor_pkg;

   // Tag field is sized for the smallest useful index; unused upper bits stay zero.
   localparam int TAG_W = 30;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } bp_ctr_t;

   typedef struct packed {
      logic              valid;
      logic [TAG_W-1:0]  tag;
      logic [31:0]       target;
   } btb_entry_t;

   localparam bp_ctr_t PHT_RESET = WNT;

   // Saturating 2-bit counter step: never wraps past ST or SNT.
   function automatic bp_ctr_t ctr_next(input bp_ctr_t c, input logic up);
      bp_ctr_t n;
      n = c;
      case (c)
         SNT:     n = up ? WNT : SNT;
         WNT:     n = up ? WT  : SNT;
         WT:      n = up ? ST  : WNT;
         ST:      n = up ? ST  : WT;
         default: n = c;
      endcase
      return n;
   endfunction

   function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] pc, input int unsigned idx_bits);
      return TAG_W'(pc >> (idx_bits + 2));
   endfunction

endpackage

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer (module bp_btb): combinational read,
// synchronous write. Only the valid bits are cleared by reset.
module bp_btb
   import branch_predictor_pkg::*;
#(
   parameter int IDX_BITS = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [IDX_BITS-1:0] rd_idx,
   output btb_entry_t          rd_entry,
   input  logic                wr_en,
   input  logic [IDX_BITS-1:0] wr_idx,
   input  logic [TAG_W-1:0]    wr_tag,
   input  logic [31:0]         wr_target
);

   localparam int DEPTH = 1 << IDX_BITS;

   logic              valid_q  [DEPTH];
   logic [TAG_W-1:0]  tag_q    [DEPTH];
   logic [31:0]       target_q [DEPTH];

   // NOTE: state is written with <= so every reader in this edge sees pre-update values.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) valid_q[i] <= 1'b0;
      end else if (wr_en) begin
         valid_q[wr_idx] <= 1'b1;
      end
   end

   // NOTE: tag/target arrays carry no reset; a cleared valid bit makes their contents irrelevant.
   always_ff @(posedge clk) begin
      if (!rst && wr_en) begin
         tag_q[wr_idx]    <= wr_tag;
         target_q[wr_idx] <= wr_target;
      end
   end

   always_comb begin
      rd_entry.valid  = valid_q[rd_idx];
      rd_entry.tag    = tag_q[rd_idx];
      rd_entry.target = target_q[rd_idx];
   end

endmodule

// File: rtl/branch_predictor.sv
// IF-stage branch predictor: BTB plus PHT of 2-bit counters, trained from EX.
// Define BRANCH_PRED_GSHARE_EN to XOR a global history register into the PHT index.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int IDX_BITS = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] fetch_pc,
   output logic        pred_hit,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic        upd_br_en,
   input  logic [31:0] upd_target
);

   localparam int DEPTH = 1 << IDX_BITS;

   logic [IDX_BITS-1:0] fetch_idx;
   logic [IDX_BITS-1:0] upd_idx;
   logic [IDX_BITS-1:0] fetch_pidx;
   logic [IDX_BITS-1:0] upd_pidx;

   assign fetch_idx = fetch_pc[IDX_BITS+1:2];
   assign upd_idx   = upd_pc[IDX_BITS+1:2];

`ifdef BRANCH_PRED_GSHARE_EN
   logic [IDX_BITS-1:0] ghr;

   // History is trained at resolve time, so it is non-speculative.
   always_ff @(posedge clk) begin
      if (rst)            ghr <= '0;
      else if (upd_valid) ghr <= {ghr[IDX_BITS-2:0], upd_br_en};
   end

   assign fetch_pidx = fetch_idx ^ ghr;
   assign upd_pidx   = upd_idx ^ ghr;
`else
   assign fetch_pidx = fetch_idx;
   assign upd_pidx   = upd_idx;
`endif

   bp_ctr_t pht_q [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) pht_q[i] <= PHT_RESET;
      end else if (upd_valid) begin
         pht_q[upd_pidx] <= ctr_next(pht_q[upd_pidx], upd_br_en);
      end
   end

   btb_entry_t btb_rd;

   // Only taken outcomes allocate; a taken alias simply overwrites the slot.
   bp_btb #(.IDX_BITS(IDX_BITS)) u_btb (
      .clk       (clk),
      .rst       (rst),
      .rd_idx    (fetch_idx),
      .rd_entry  (btb_rd),
      .wr_en     (upd_valid && upd_br_en),
      .wr_idx    (upd_idx),
      .wr_tag    (tag_of(upd_pc, IDX_BITS)),
      .wr_target (upd_target)
   );

   logic [1:0] lookup_ctr;

   // NOTE: every output gets a default first so no path through this block infers a latch.
   always_comb begin
      pred_hit    = 1'b0;
      pred_taken  = 1'b0;
      pred_target = fetch_pc + 32'd4;
      lookup_ctr  = pht_q[fetch_pidx];
      if (btb_rd.valid && (btb_rd.tag == tag_of(fetch_pc, IDX_BITS))) begin
         pred_hit = 1'b1;
      end
      if (pred_hit && lookup_ctr[1]) begin
         pred_taken  = 1'b1;
         pred_target = btb_rd.target;
      end
   end

   // Word-aligned PCs: the byte offset of a resolved branch carries no information.
   logic unused_upd_pc_lsbs;
   assign unused_upd_pc_lsbs = ^upd_pc[1:0];

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (IDX_BITS=6).
// Bimodal scenarios run by default; the gshare scenario runs with BRANCH_PRED_GSHARE_EN.
module tb_branch_predictor;

   logic        clk;
   logic        rst;
   logic [31:0] fetch_pc;
   logic        pred_hit;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_br_en;
   logic [31:0] upd_target;

   int checks;
   int failures;

   branch_predictor #(.IDX_BITS(6)) dut (
      .clk         (clk),
      .rst         (rst),
      .fetch_pc    (fetch_pc),
      .pred_hit    (pred_hit),
      .pred_taken  (pred_taken),
      .pred_target (pred_target),
      .upd_valid   (upd_valid),
      .upd_pc      (upd_pc),
      .upd_br_en   (upd_br_en),
      .upd_target  (upd_target)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_update(input logic [31:0] pc, input logic br_en, input logic [31:0] tgt);
      upd_valid  = 1'b1;
      upd_pc     = pc;
      upd_br_en  = br_en;
      upd_target = tgt;
      next_cycle();
      upd_valid  = 1'b0;
      #1;
   endtask

   task automatic apply_reset();
      rst       = 1'b1;
      upd_valid = 1'b0;
      next_cycle();
      next_cycle();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      apply_reset();
      fetch_pc = 32'h6000_0040;
      #1;
      checks++; if (pred_hit !== 1'b0) begin failures++; $display("FAIL reset_hit: got %b expected 0", pred_hit); end
      checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL reset_taken: got %b expected 0", pred_taken); end
      checks++; if (pred_target !== 32'h6000_0044) begin failures++; $display("FAIL reset_target: got %h expected 60000044", pred_target); end
   endtask

   task automatic test_allocate();
      fetch_pc   = 32'h6000_0040;
      upd_valid  = 1'b1;
      upd_pc     = 32'h6000_0040;
      upd_br_en  = 1'b1;
      upd_target = 32'h6000_0100;
      #1;
      checks++; if (pred_hit !== 1'b0) begin failures++; $display("FAIL alloc_same_cycle_hit: got %b expected 0", pred_hit); end
      next_cycle();
      upd_valid = 1'b0;
      #1;
      checks++; if (pred_hit !== 1'b1) begin failures++; $display("FAIL alloc_hit: got %b expected 1", pred_hit); end
      checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL alloc_taken: got %b expected 1", pred_taken); end
      checks++; if (pred_target !== 32'h6000_0100) begin failures++; $display("FAIL alloc_target: got %h expected 60000100", pred_target); end
   endtask

   // Counter enters at WT from the allocating update.
   task automatic test_saturation();
      fetch_pc = 32'h6000_0040;
      do_update(32'h6000_0040, 1'b1, 32'h6000_0100);
      do_update(32'h6000_0040, 1'b1, 32'h6000_0100);
      do_update(32'h6000_0040, 1'b0, 32'h0);
      checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL sat_high_taken: got %b expected 1", pred_taken); end
      do_update(32'h6000_0040, 1'b0, 32'h0);
      do_update(32'h6000_0040, 1'b0, 32'h0);
      checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL sat_snt_taken: got %b expected 0", pred_taken); end
      checks++; if (pred_hit !== 1'b1) begin failures++; $display("FAIL sat_snt_hit: got %b expected 1", pred_hit); end
      checks++; if (pred_target !== 32'h6000_0044) begin failures++; $display("FAIL sat_snt_target: got %h expected 60000044", pred_target); end
      do_update(32'h6000_0040, 1'b0, 32'h0);
      checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL sat_low_taken: got %b expected 0", pred_taken); end
      do_update(32'h6000_0040, 1'b1, 32'h6000_0100);
      checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL sat_low_step1_taken: got %b expected 0", pred_taken); end
      do_update(32'h6000_0040, 1'b1, 32'h6000_0100);
      checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL sat_low_step2_taken: got %b expected 1", pred_taken); end
   endtask

   // 0x6000_0140 shares index 0x10 with 0x6000_0040 but has a different tag.
   task automatic test_alias();
      do_update(32'h6000_0140, 1'b1, 32'h6000_0200);
      fetch_pc = 32'h6000_0040;
      #1;
      checks++; if (pred_hit !== 1'b0) begin failures++; $display("FAIL alias_old_hit: got %b expected 0", pred_hit); end
      checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL alias_old_taken: got %b expected 0", pred_taken); end
      checks++; if (pred_target !== 32'h6000_0044) begin failures++; $display("FAIL alias_old_target: got %h expected 60000044", pred_target); end
      fetch_pc = 32'h6000_0140;
      #1;
      checks++; if (pred_hit !== 1'b1) begin failures++; $display("FAIL alias_new_hit: got %b expected 1", pred_hit); end
      checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL alias_new_taken: got %b expected 1", pred_taken); end
      checks++; if (pred_target !== 32'h6000_0200) begin failures++; $display("FAIL alias_new_target: got %h expected 60000200", pred_target); end
   endtask

   // Two taken updates from WNT must reach ST, so one not-taken still predicts taken.
   task automatic test_back_to_back();
      apply_reset();
      fetch_pc = 32'h6000_0080;
      upd_valid  = 1'b1;
      upd_pc     = 32'h6000_0080;
      upd_br_en  = 1'b1;
      upd_target = 32'h6000_0300;
      next_cycle();
      next_cycle();
      upd_br_en = 1'b0;
      next_cycle();
      upd_valid = 1'b0;
      #1;
      checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL b2b_taken: got %b expected 1", pred_taken); end
      checks++; if (pred_target !== 32'h6000_0300) begin failures++; $display("FAIL b2b_target: got %h expected 60000300", pred_target); end
   endtask

   task automatic test_not_taken_no_alloc();
      do_update(32'h6000_00c0, 1'b0, 32'h6000_0500);
      fetch_pc = 32'h6000_00c0;
      #1;
      checks++; if (pred_hit !== 1'b0) begin failures++; $display("FAIL nt_alloc_hit: got %b expected 0", pred_hit); end
      checks++; if (pred_target !== 32'h6000_00c4) begin failures++; $display("FAIL nt_alloc_target: got %h expected 600000c4", pred_target); end
   endtask

   // First taken update trains PHT[0x10] and shifts ghr to 000001; lookup then reads PHT[0x11].
   task automatic test_gshare();
      apply_reset();
      do_update(32'h6000_0040, 1'b1, 32'h6000_0100);
      fetch_pc = 32'h6000_0040;
      #1;
      checks++; if (pred_hit !== 1'b1) begin failures++; $display("FAIL gshare_hit: got %b expected 1", pred_hit); end
      checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL gshare_taken: got %b expected 0", pred_taken); end
      checks++; if (pred_target !== 32'h6000_0044) begin failures++; $display("FAIL gshare_target: got %h expected 60000044", pred_target); end
   endtask

   task automatic test_reset_with_update();
      fetch_pc   = 32'h6000_0240;
      rst        = 1'b1;
      upd_valid  = 1'b1;
      upd_pc     = 32'h6000_0240;
      upd_br_en  = 1'b1;
      upd_target = 32'h6000_0600;
      next_cycle();
      rst       = 1'b0;
      upd_valid = 1'b0;
      #1;
      checks++; if (pred_hit !== 1'b0) begin failures++; $display("FAIL rst_upd_hit: got %b expected 0", pred_hit); end
      checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL rst_upd_taken: got %b expected 0", pred_taken); end
      checks++; if (pred_target !== 32'h6000_0244) begin failures++; $display("FAIL rst_upd_target: got %h expected 60000244", pred_target); end
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      rst        = 1'b1;
      fetch_pc   = 32'h0;
      upd_valid  = 1'b0;
      upd_pc     = 32'h0;
      upd_br_en  = 1'b0;
      upd_target = 32'h0;

      test_reset();
`ifdef BRANCH_PRED_GSHARE_EN
      test_gshare();
`else
      test_allocate();
      test_saturation();
      test_alias();
      test_back_to_back();
`endif
      test_not_taken_no_alloc();
      test_reset_with_update();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
